e203_nice_csr_arb: RTL
======================

E203_NICE_CSR_ARB -- requirements
Module: e203_nice_csr_arb

Interface
REQ-001 Parameter TIMEOUT_CYC, default 255, meaning max ISSUE cycles awaiting nice_csr_ready before error completion (range 1..255).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 req0_valid/req1_valid  input  1 each  requester n (0 = core CSR unit, 1 = debug module) presents an access.
REQ-005 req0_ready/req1_ready  output  1 each  requester n access accepted this cycle.
REQ-006 reqN_addr  input  32, reqN_wr  input  1, reqN_wdata  input  32  access fields, sampled at acceptance.
REQ-007 rsp0_valid/rsp1_valid  output  1 each  response to requester n pending.
REQ-008 rsp0_ready/rsp1_ready  input  1 each  requester n consumes response.
REQ-009 rspN_rdata  output  32, rspN_err  output  1  read data / timeout flag.
REQ-010 nice_csr_valid  output  1, nice_csr_ready  input  1  downstream extended-CSR handshake.
REQ-011 nice_csr_addr  output  32, nice_csr_wr  output  1, nice_csr_wdata  output  32, nice_csr_rdata  input  32  downstream fields.

Function
REQ-012 FSM states IDLE, ISSUE, RESP; one access outstanding at a time.
REQ-013 IDLE: if any reqN_valid, grant one; reqN_ready=1 combinationally for granted requester only; latch addr/wr/wdata and grant id; next state ISSUE.
REQ-014 reqN_ready SHALL be 0 outside IDLE and for the non-granted requester.
REQ-015 Arbitration round-robin: both valid -> requester not last granted wins; after reset requester 0 has priority.
REQ-016 Priority pointer updates only on grant (granted id becomes lowest priority).
REQ-017 ISSUE: nice_csr_valid=1 with latched fields held stable; no other output changes until completion.
REQ-018 Completion when nice_csr_valid & nice_csr_ready: capture nice_csr_rdata for reads, 0 for writes; err=0; next RESP.
REQ-019 Timeout counter (8-bit) clears on entering ISSUE, increments each ISSUE cycle without ready; at count == TIMEOUT_CYC-1 without ready: rdata=0, err=1, drop nice_csr_valid next cycle, next RESP.
REQ-020 Ready and timeout in same cycle: ready wins, err=0.
REQ-021 Minimum latency: accept cycle t, nice_csr_valid at t+1, rspN_valid at t+2 if downstream ready at t+1.
REQ-022 RESP: rspN_valid=1 for granted requester only, rdata/err held stable until rspN_ready; on rspN_valid & rspN_ready next IDLE.
REQ-023 No new acceptance in the RESP-exit cycle; next grant earliest the cycle after.
REQ-024 rspN_rdata/rspN_err SHALL read 0 whenever rspN_valid=0.

Reset
REQ-025 Sampled rst_n=0: state IDLE, pointer to requester 0, counter 0, latched fields 0.
REQ-026 Output reset values: all reqN_ready 0, rspN_valid 0, rspN_rdata 0, rspN_err 0, nice_csr_valid 0, nice_csr_addr/wr/wdata 0.
REQ-027 Reset mid-ISSUE or mid-RESP abandons the access; no response is produced after reset.

Structure
REQ-028 State enum typedef and default timeout constant SHALL live in shared package e203_csr_pkg.
REQ-029 Two-way round-robin grant logic SHALL be sub-module e203_rr_arb2 (inputs req[1:0], update; output grant[1:0]).
REQ-030 Implementation 120-400 lines; no combinational path from nice_csr_ready to nice_csr_valid.

Verification
REQ-031 Single read: req0 addr=0xBC0, wr=0; downstream ready at once, rdata=0xDEADBEEF -> rsp0_valid 2 cycles after acceptance, rdata=0xDEADBEEF, err=0.
REQ-032 Write: req1 addr=0xBC4, wdata=0x12345678 -> nice_csr_wr=1, wdata=0x12345678 held through ISSUE; rsp1_rdata=0, err=0.
REQ-033 Contention: both valid continuously, downstream always ready -> grants alternate 0,1,0,1 from reset.
REQ-034 Timeout: TIMEOUT_CYC=4, nice_csr_ready stuck 0 -> nice_csr_valid high exactly 4 cycles, rspN_err=1, rdata=0.
REQ-035 Backpressure: rsp0_ready low 5 cycles -> rsp0_valid/rdata stable, req1 not accepted until rsp0 handshake.
REQ-036 Reset mid-ISSUE: rst_n=0 one cycle during ISSUE -> next cycle all outputs at reset values, no rspN_valid.

Source files
------------

// File: rtl/e203_csr_pkg.sv
// Shared types and constants for the NICE extended-CSR access arbiter.
package e203_csr_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2
    } csr_state_e;

    localparam int unsigned DEFAULT_TIMEOUT_CYC = 255;

endpackage

// File: rtl/e203_rr_arb2.sv
// Two-way round-robin arbiter; the pointer names the requester that wins a tie.
module e203_rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       update,
    output logic [1:0] grant
);

    logic prio_q;
    logic prio_d;

    always_comb begin
        grant  = req;
        prio_d = prio_q;
        if (req == 2'b11) begin
            grant = prio_q ? 2'b10 : 2'b01;
        end
        // The requester just served drops to lowest priority.
        if (update && (grant != 2'b00)) begin
            prio_d = ~grant[1];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prio_q <= 1'b0;
        end else begin
            prio_q <= prio_d;
        end
    end

endmodule

// File: rtl/e203_nice_csr_arb.sv
// Arbitrates core and debug CSR accesses onto a single NICE extended-CSR port,
// one access outstanding, with a bounded wait for the downstream handshake.
module e203_nice_csr_arb
    import e203_csr_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = DEFAULT_TIMEOUT_CYC
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [31:0] req0_addr,
    input  logic        req0_wr,
    input  logic [31:0] req0_wdata,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [31:0] req1_addr,
    input  logic        req1_wr,
    input  logic [31:0] req1_wdata,
    output logic        rsp0_valid,
    input  logic        rsp0_ready,
    output logic [31:0] rsp0_rdata,
    output logic        rsp0_err,
    output logic        rsp1_valid,
    input  logic        rsp1_ready,
    output logic [31:0] rsp1_rdata,
    output logic        rsp1_err,
    output logic        nice_csr_valid,
    input  logic        nice_csr_ready,
    output logic [31:0] nice_csr_addr,
    output logic        nice_csr_wr,
    output logic [31:0] nice_csr_wdata,
    input  logic [31:0] nice_csr_rdata
);

    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYC - 1);

    csr_state_e  state_q, state_d;
    logic        gnt_id_q, gnt_id_d;
    logic [31:0] addr_q, addr_d;
    logic        wr_q, wr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;
    logic [7:0]  cnt_q, cnt_d;

    logic [1:0]  arb_grant;
    logic        arb_update;
    logic        rsp_hs;

    e203_rr_arb2 u_rr_arb2 (
        .clk    (clk),
        .rst_n  (rst_n),
        .req    ({req1_valid, req0_valid}),
        .update (arb_update),
        .grant  (arb_grant)
    );

    assign rsp_hs = gnt_id_q ? rsp1_ready : rsp0_ready;

    always_comb begin
        state_d        = state_q;
        gnt_id_d       = gnt_id_q;
        addr_d         = addr_q;
        wr_d           = wr_q;
        wdata_d        = wdata_q;
        rdata_d        = rdata_q;
        err_d          = err_q;
        cnt_d          = cnt_q;
        arb_update     = 1'b0;
        req0_ready     = 1'b0;
        req1_ready     = 1'b0;
        nice_csr_valid = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (arb_grant != 2'b00) begin
                    arb_update = 1'b1;
                    req0_ready = arb_grant[0];
                    req1_ready = arb_grant[1];
                    gnt_id_d   = arb_grant[1];
                    addr_d     = arb_grant[1] ? req1_addr  : req0_addr;
                    wr_d       = arb_grant[1] ? req1_wr    : req0_wr;
                    wdata_d    = arb_grant[1] ? req1_wdata : req0_wdata;
                    cnt_d      = 8'd0;
                    state_d    = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                nice_csr_valid = 1'b1;
                // A handshake in the final allowed cycle still completes normally.
                if (nice_csr_ready) begin
                    rdata_d = wr_q ? 32'd0 : nice_csr_rdata;
                    err_d   = 1'b0;
                    state_d = ST_RESP;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    rdata_d = 32'd0;
                    err_d   = 1'b1;
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ST_RESP: begin
                if (rsp_hs) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            gnt_id_q <= 1'b0;
            addr_q   <= 32'd0;
            wr_q     <= 1'b0;
            wdata_q  <= 32'd0;
            rdata_q  <= 32'd0;
            err_q    <= 1'b0;
            cnt_q    <= 8'd0;
        end else begin
            state_q  <= state_d;
            gnt_id_q <= gnt_id_d;
            addr_q   <= addr_d;
            wr_q     <= wr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
            cnt_q    <= cnt_d;
        end
    end

    assign nice_csr_addr  = addr_q;
    assign nice_csr_wr    = wr_q;
    assign nice_csr_wdata = wdata_q;

    assign rsp0_valid = (state_q == ST_RESP) && !gnt_id_q;
    assign rsp1_valid = (state_q == ST_RESP) &&  gnt_id_q;
    assign rsp0_rdata = rsp0_valid ? rdata_q : 32'd0;
    assign rsp1_rdata = rsp1_valid ? rdata_q : 32'd0;
    assign rsp0_err   = rsp0_valid & err_q;
    assign rsp1_err   = rsp1_valid & err_q;

endmodule
